pkt_ring_buf: RTL and testbench

PKT_RING_BUF -- requirements
Module: pkt_ring_buf

---
 rtl/pkt_ring_pkg.sv | 23 ++
 rtl/pkt_ring_ram.sv | 42 ++++
 rtl/pkt_ring_buf.sv | 249 ++++++++++++++++++++++++
 tb/tb_pkt_ring_buf.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_ring_pkg.sv
// Shared definitions for the packet ring buffer: read FSM encoding and width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pkt_ring_pkg;

   // Read-side sequencer states
   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_LOAD   = 2'd1,
      RD_STREAM = 2'd2
   } rd_state_t;

   // Bits needed to address 'depth' entries (never less than one bit)
   function automatic int ptr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Bits needed to hold a count from 0 up to and including 'depth'
   function automatic int len_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pkt_ring_ram.sv
// Simple dual-port word store: one write port, one registered read port.
// Latency: read data appears the cycle after i_re is sampled high.
// Backpressure: none; read register holds its value while i_re is low.
module pkt_ring_ram
   import pkt_ring_pkg::*;
#(
   parameter int pBITS  = 8,
   parameter int pDEPTH = 16,
   parameter int pAW    = ptr_bits(pDEPTH)
)(
   input  logic             iclk,
   input  logic             irst,
   input  logic             i_we,
   input  logic [pAW-1:0]   i_waddr,
   input  logic [pBITS-1:0] i_wdata,
   input  logic             i_re,
   input  logic [pAW-1:0]   i_raddr,
   output logic [pBITS-1:0] o_rdata
);

   logic [pBITS-1:0] r_mem [pDEPTH];
   logic [pBITS-1:0] r_q;

   // Storage array: contents survive reset
   always_ff @(posedge iclk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port; cleared by reset so the read word output starts at zero
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_q <= '0;
      end else if (i_re) begin
         r_q <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/pkt_ring_buf.sv
// Packet ring buffer: stores whole packets, drops on overflow, discards on abort, streams committed packets out.
// Latency: last write beat at cycle N gives first ord_valid at N+3; two idle cycles between packets.
// Backpressure: none on write (overflowing packets are dropped); read side holds word while ird_ready is low.
module pkt_ring_buf
   import pkt_ring_pkg::*;
#(
   parameter int pBITS  = 8,
   parameter int pDEPTH = 3072,
   parameter int pPKTS  = 16
)(
   input  logic                       iclk,
   input  logic                       irst,
   input  logic                       iwr_valid,
   input  logic [pBITS-1:0]           iwr_data,
   input  logic                       iwr_last,
   input  logic                       iwr_abort,
   output logic                       ord_valid,
   output logic [pBITS-1:0]           ord_data,
   output logic                       ord_last,
   input  logic                       ird_ready,
   output logic [$clog2(pPKTS+1)-1:0] opkt_cnt,
   output logic                       odrop
);

   localparam int PW = ptr_bits(pDEPTH);
   localparam int LW = len_bits(pDEPTH);
   localparam int CW = $clog2(pPKTS + 1);
   localparam int QW = ptr_bits(pPKTS);

   localparam logic [PW-1:0] cPTR_MAX = PW'(pDEPTH - 1);
   localparam logic [LW-1:0] cDEPTH   = LW'(pDEPTH);
   localparam logic [CW-1:0] cPKTS    = CW'(pPKTS);
   localparam logic [QW-1:0] cQ_MAX   = QW'(pPKTS - 1);

   // Write-side state
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_sp;
   logic [LW-1:0] r_len;
   logic [LW-1:0] r_used;
   logic          r_flag;
   logic          r_drop;
   logic [CW-1:0] r_cnt;

   // Committed-length queue
   logic [LW-1:0] r_lq [pPKTS];
   logic [QW-1:0] r_lq_wp;
   logic [QW-1:0] r_lq_rp;

   // Read-side state
   rd_state_t     r_state;
   logic [PW-1:0] r_rp;
   logic [LW-1:0] r_plen;
   logic [LW-1:0] r_idx;

   // Combinational decisions
   logic          w_full;
   logic          w_first;
   logic          w_ovf;
   logic          w_abort;
   logic          w_wr;
   logic          w_commit;
   logic          w_drop;
   logic          w_setflag;
   logic          w_rollback;
   logic [PW-1:0] w_wp_inc;
   logic [PW-1:0] w_rp_inc;
   logic [LW-1:0] w_used_nxt;
   rd_state_t     w_state_nxt;
   logic          w_rd_en;
   logic [PW-1:0] w_rd_addr;
   logic          w_load;
   logic          w_hs;
   logic          w_ord_last;
   logic          w_last_hs;
   logic [QW-1:0] w_lq_wp_inc;
   logic [QW-1:0] w_lq_rp_inc;

   assign w_wp_inc    = (r_wp == cPTR_MAX) ? '0 : r_wp + PW'(1);
   assign w_rp_inc    = (r_rp == cPTR_MAX) ? '0 : r_rp + PW'(1);
   assign w_lq_wp_inc = (r_lq_wp == cQ_MAX) ? '0 : r_lq_wp + QW'(1);
   assign w_lq_rp_inc = (r_lq_rp == cQ_MAX) ? '0 : r_lq_rp + QW'(1);

   // Classify the current write beat; overflow is judged on pre-edge occupancy
   always_comb begin
      w_full     = (r_used == cDEPTH);
      w_first    = (r_len == '0) && !r_flag;
      w_ovf      = r_flag || w_full || (w_first && (r_cnt == cPKTS));
      w_abort    = iwr_valid && iwr_abort;
      w_wr       = iwr_valid && !iwr_abort && !w_ovf;
      w_commit   = w_wr && iwr_last;
      w_drop     = iwr_valid && !iwr_abort && w_ovf && iwr_last;
      w_setflag  = iwr_valid && !iwr_abort && w_ovf && !iwr_last;
      w_rollback = w_abort || w_drop;
   end

   // Occupancy counts every word from rp to wp, including the open packet
   always_comb begin
      w_used_nxt = r_used;
      if (w_wr) begin
         w_used_nxt = w_used_nxt + LW'(1);
      end
      if (w_hs) begin
         w_used_nxt = w_used_nxt - LW'(1);
      end
      if (w_rollback) begin
         w_used_nxt = w_used_nxt - r_len;
      end
   end

   // Write pointers, open-packet length, overflow flag and drop pulse
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_wp   <= '0;
         r_sp   <= '0;
         r_len  <= '0;
         r_used <= '0;
         r_flag <= 1'b0;
         r_drop <= 1'b0;
      end else begin
         r_used <= w_used_nxt;
         r_drop <= w_drop;
         if (w_rollback) begin
            r_wp   <= r_sp;
            r_len  <= '0;
            r_flag <= 1'b0;
         end else if (w_setflag) begin
            r_flag <= 1'b1;
         end else if (w_wr) begin
            r_wp <= w_wp_inc;
            if (iwr_last) begin
               r_sp  <= w_wp_inc;
               r_len <= '0;
            end else begin
               r_len <= r_len + LW'(1);
            end
         end
      end
   end

   // Length queue push on commit, pop on load; packet count tracks commits minus finished reads
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         for (int i = 0; i < pPKTS; i++) begin
            r_lq[i] <= '0;
         end
         r_lq_wp <= '0;
         r_lq_rp <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_commit) begin
            r_lq[r_lq_wp] <= r_len + LW'(1);
            r_lq_wp       <= w_lq_wp_inc;
         end
         if (w_load) begin
            r_lq_rp <= w_lq_rp_inc;
         end
         case ({w_commit, w_last_hs})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Read FSM state register
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_state <= RD_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Read FSM next state, RAM read control and valid; a handshake prefetches rp+1
   always_comb begin
      w_state_nxt = r_state;
      ord_valid   = 1'b0;
      w_rd_en     = 1'b0;
      w_rd_addr   = r_rp;
      w_load      = 1'b0;
      case (r_state)
         RD_IDLE: begin
            if (r_cnt != '0) begin
               w_state_nxt = RD_LOAD;
            end
         end
         RD_LOAD: begin
            w_rd_en     = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = RD_STREAM;
         end
         RD_STREAM: begin
            ord_valid = 1'b1;
            w_rd_en   = 1'b1;
            if (ird_ready) begin
               w_rd_addr = w_rp_inc;
               if (w_ord_last) begin
                  w_state_nxt = RD_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = RD_IDLE;
         end
      endcase
   end

   assign w_ord_last = (r_state == RD_STREAM) && (r_idx == (r_plen - LW'(1)));
   assign w_hs       = ord_valid && ird_ready;
   assign w_last_hs  = w_hs && w_ord_last;

   // Read pointer, popped packet length and in-packet word index
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_rp   <= '0;
         r_plen <= '0;
         r_idx  <= '0;
      end else begin
         if (w_load) begin
            r_plen <= r_lq[r_lq_rp];
            r_idx  <= '0;
         end
         if (w_hs) begin
            r_rp  <= w_rp_inc;
            r_idx <= w_ord_last ? '0 : r_idx + LW'(1);
         end
      end
   end

   pkt_ring_ram #(
      .pBITS  (pBITS),
      .pDEPTH (pDEPTH),
      .pAW    (PW)
   ) u_ram (
      .iclk    (iclk),
      .irst    (irst),
      .i_we    (w_wr),
      .i_waddr (r_wp),
      .i_wdata (iwr_data),
      .i_re    (w_rd_en),
      .i_raddr (w_rd_addr),
      .o_rdata (ord_data)
   );

   assign ord_last = w_ord_last;
   assign opkt_cnt = r_cnt;
   assign odrop    = r_drop;

endmodule

// File: tb/tb_pkt_ring_buf.sv
// Bench for pkt_ring_buf (8-bit words, 16-word ring, 4 packets): scoreboard of expected read words.
// Stimulus pushes expected words; a negedge monitor compares every presented word against the queue head.
// Drop pulses are counted and checked for single-cycle width.
module tb_pkt_ring_buf;

   logic       iclk      = 1'b0;
   logic       irst      = 1'b1;
   logic       iwr_valid = 1'b0;
   logic [7:0] iwr_data  = 8'h00;
   logic       iwr_last  = 1'b0;
   logic       iwr_abort = 1'b0;
   logic       ird_ready = 1'b0;
   logic       ord_valid;
   logic [7:0] ord_data;
   logic       ord_last;
   logic [2:0] opkt_cnt;
   logic       odrop;

   int   checks     = 0;
   int   errors     = 0;
   int   drops_seen = 0;
   int   rdy_mode   = 1;
   logic prev_drop  = 1'b0;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;
   exp_t exp_q[$];

   always #5 iclk = ~iclk;

   pkt_ring_buf #(
      .pBITS  (8),
      .pDEPTH (16),
      .pPKTS  (4)
   ) dut (
      .iclk      (iclk),
      .irst      (irst),
      .iwr_valid (iwr_valid),
      .iwr_data  (iwr_data),
      .iwr_last  (iwr_last),
      .iwr_abort (iwr_abort),
      .ord_valid (ord_valid),
      .ord_data  (ord_data),
      .ord_last  (ord_last),
      .ird_ready (ird_ready),
      .opkt_cnt  (opkt_cnt),
      .odrop     (odrop)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic expect_pkt(input int n, input logic [7:0] base);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.d = base + 8'(k);
         e.l = (k == n - 1);
         exp_q.push_back(e);
      end
   endtask

   // One beat per cycle; stops after an abort beat
   task automatic send(input int n, input logic [7:0] base, input int abort_at);
      for (int k = 0; k < n; k++) begin
         @(posedge iclk);
         #1;
         iwr_valid = 1'b1;
         iwr_data  = base + 8'(k);
         iwr_last  = (k == n - 1);
         iwr_abort = (k == abort_at);
         if (k == abort_at) break;
      end
      @(posedge iclk);
      #1;
      iwr_valid = 1'b0;
      iwr_last  = 1'b0;
      iwr_abort = 1'b0;
   endtask

   task automatic drain(input string name, input int maxc);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < maxc) begin
         @(negedge iclk);
         c++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge iclk);
   endtask

   // Consumer ready: 0 = stall, 1 = always ready, otherwise random
   always @(posedge iclk) begin
      #1;
      case (rdy_mode)
         0:       ird_ready = 1'b0;
         1:       ird_ready = 1'b1;
         default: ird_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: every presented word must match the queue head; pop on handshake
   always @(negedge iclk) begin
      if (!irst) begin
         if (ord_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word got %0h last %0b expected none at %0t", ord_data, ord_last, $time);
            end else begin
               chk("rd_data", 32'(ord_data), 32'(exp_q[0].d));
               chk("rd_last", 32'(ord_last), 32'(exp_q[0].l));
               if (ird_ready) begin
                  void'(exp_q.pop_front());
               end
            end
         end
         if (odrop) begin
            drops_seen++;
            chk("odrop_width", 32'(prev_drop), 32'd0);
         end
         prev_drop = odrop;
      end else begin
         prev_drop = 1'b0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] pat;
      int          w;

      // Reset values
      #12;
      chk("rst0_valid", 32'(ord_valid), 32'd0);
      chk("rst0_last",  32'(ord_last),  32'd0);
      chk("rst0_drop",  32'(odrop),     32'd0);
      chk("rst0_cnt",   32'(opkt_cnt),  32'd0);
      chk("rst0_data",  32'(ord_data),  32'd0);
      @(negedge iclk);
      irst = 1'b0;
      repeat (2) @(negedge iclk);

      // 5-word packet, always ready: latency N+3, 5 consecutive words
      expect_pkt(5, 8'h01);
      send(5, 8'h01, -1);
      @(negedge iclk);
      chk("lat_n1_valid", 32'(ord_valid), 32'd0);
      chk("lat_n1_cnt",   32'(opkt_cnt),  32'd1);
      @(negedge iclk);
      chk("lat_n2_valid", 32'(ord_valid), 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge iclk);
         chk("stream_valid", 32'(ord_valid), 32'd1);
      end
      @(negedge iclk);
      chk("stream_end_valid", 32'(ord_valid), 32'd0);
      chk("stream_end_cnt",   32'(opkt_cnt),  32'd0);

      // Abort mid-packet, then a good packet, then abort together with last
      send(3, 8'h10, 1);
      expect_pkt(2, 8'hA0);
      send(2, 8'hA0, -1);
      send(1, 8'h70, 0);
      drain("drain_abort", 50);
      chk("abort_cnt",   32'(opkt_cnt),   32'd0);
      chk("abort_drops", 32'(drops_seen), 32'd0);

      // Overflow: 12 words stored, 6-word packet dropped, 4-word packet fits in the restored space
      @(negedge iclk);
      rdy_mode = 0;
      repeat (2) @(negedge iclk);
      expect_pkt(12, 8'h20);
      send(12, 8'h20, -1);
      send(6, 8'h40, -1);
      @(negedge iclk);
      chk("ovf_drop_pulse", 32'(odrop), 32'd1);
      @(negedge iclk);
      chk("ovf_drop_clear", 32'(odrop),    32'd0);
      chk("ovf_cnt",        32'(opkt_cnt), 32'd1);
      expect_pkt(4, 8'h50);
      send(4, 8'h50, -1);
      @(negedge iclk);
      chk("refill_cnt",    32'(opkt_cnt),  32'd2);
      chk("stalled_valid", 32'(ord_valid), 32'd1);
      @(negedge iclk);
      rdy_mode = 1;
      drain("drain_ovf", 100);
      chk("ovf_drops", 32'(drops_seen), 32'd1);

      // Packet-count saturation: 4 one-word packets kept, 5th dropped
      @(negedge iclk);
      rdy_mode = 0;
      repeat (2) @(negedge iclk);
      for (int p = 0; p < 5; p++) begin
         if (p < 4) expect_pkt(1, 8'h60 + 8'(p));
         send(1, 8'h60 + 8'(p), -1);
      end
      @(negedge iclk);
      chk("sat_cnt",        32'(opkt_cnt), 32'd4);
      chk("sat_drop_pulse", 32'(odrop),    32'd1);
      @(negedge iclk);
      chk("sat_drops", 32'(drops_seen), 32'd2);
      rdy_mode = 1;
      pat = '0;
      for (int c = 0; c < 12; c++) begin
         @(negedge iclk);
         pat = {pat[10:0], ord_valid};
      end
      chk("gap_pattern", 32'(pat), 32'h924);
      drain("drain_sat", 20);
      chk("sat_cnt_end", 32'(opkt_cnt), 32'd0);

      // 40 three-word packets with random ready, wrapping the ring several times
      @(negedge iclk);
      rdy_mode = 2;
      for (int p = 0; p < 40; p++) begin
         w = 0;
         while (opkt_cnt > 3'd1 && w < 200) begin
            @(negedge iclk);
            w++;
         end
         chk("wrap_room", 32'(opkt_cnt > 3'd1), 32'd0);
         expect_pkt(3, 8'(p * 3));
         send(3, 8'(p * 3), -1);
      end
      drain("drain_wrap", 3000);
      @(negedge iclk);
      rdy_mode = 1;
      chk("wrap_drops", 32'(drops_seen), 32'd2);

      // Reset while streaming, then a fresh packet
      repeat (2) @(negedge iclk);
      expect_pkt(6, 8'h80);
      send(6, 8'h80, -1);
      w = 0;
      while (!ord_valid && w < 10) begin
         @(negedge iclk);
         w++;
      end
      chk("rst_stream_seen", 32'(ord_valid), 32'd1);
      @(negedge iclk);
      #2;
      irst = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_mid_valid", 32'(ord_valid), 32'd0);
      chk("rst_mid_cnt",   32'(opkt_cnt),  32'd0);
      chk("rst_mid_last",  32'(ord_last),  32'd0);
      chk("rst_mid_data",  32'(ord_data),  32'd0);
      repeat (2) @(negedge iclk);
      irst = 1'b0;
      expect_pkt(3, 8'h90);
      send(3, 8'h90, -1);
      drain("drain_post_rst", 50);
      chk("final_cnt",   32'(opkt_cnt),   32'd0);
      chk("final_drops", 32'(drops_seen), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
